// File: rtl/pc.sv
// Program counter: advances by a caller-supplied step on each enabled edge,
// holds otherwise, and flags a one-cycle wrap when the add carries out.
module pc #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] increment,
  output logic [WIDTH-1:0] pc_out,
  output logic             wrap
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   sum;

  // Extra MSB captures the carry that is dropped from the counter itself.
  always_comb begin
    sum    = {1'b0, pc_q} + {1'b0, increment};
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (enable) begin
      pc_d   = sum[WIDTH-1:0];
      wrap_d = sum[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_out = pc_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_pc.sv
// Directed and random bench for pc: expected results are queued as each edge's
// inputs are driven and compared just after that edge.
module tb_pc;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         wrap;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] increment = '0;
  logic [W-1:0] pc_out;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  exp_t         sb_q[$];
  logic [W-1:0] model_pc;

  pc #(
    .WIDTH      (W),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .increment(increment),
    .pc_out   (pc_out),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [W-1:0] inc,
                      input string tag);
    exp_t          exp, got;
    logic [W:0]    s;
    @(negedge clk);
    reset     = r;
    enable    = e;
    increment = inc;
    if (r) begin
      exp.pc   = 8'h00;
      exp.wrap = 1'b0;
    end else if (e) begin
      s        = {1'b0, model_pc} + {1'b0, inc};
      exp.pc   = s[W-1:0];
      exp.wrap = s[W];
    end else begin
      exp.pc   = model_pc;
      exp.wrap = 1'b0;
    end
    model_pc = exp.pc;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checks++;
    assert (pc_out === got.pc) else begin
      errors++;
      $error("FAIL %s pc_out: got %h expected %h", tag, pc_out, got.pc);
    end
    checks++;
    assert (wrap === got.wrap) else begin
      errors++;
      $error("FAIL %s wrap: got %b expected %b", tag, wrap, got.wrap);
    end
  endtask

  initial begin
    model_pc = 'x;
    step(1'b1, 1'b0, 8'd0,   "reset");
    step(1'b0, 1'b1, 8'd5,   "step5");
    step(1'b0, 1'b1, 8'd1,   "step1");
    step(1'b0, 1'b0, 8'd5,   "hold");
    step(1'b0, 1'b1, 8'd0,   "inc0_noop");
    step(1'b1, 1'b0, 8'd9,   "reset_dis");
    step(1'b0, 1'b1, 8'd3,   "resume");
    step(1'b1, 1'b1, 8'd9,   "reset_en");
    step(1'b0, 1'b1, 8'd250, "to250");
    step(1'b0, 1'b1, 8'd10,  "wrap250");
    step(1'b0, 1'b0, 8'd10,  "wrap_clear");
    step(1'b0, 1'b1, 8'd250, "to254");
    step(1'b0, 1'b1, 8'd5,   "wrapFE");
    step(1'b0, 1'b1, 8'd252, "to255");
    step(1'b0, 1'b1, 8'd1,   "wrap_exact");
    step(1'b0, 1'b1, 8'd200, "wrap_pulse_a");
    step(1'b0, 1'b1, 8'd100, "wrap_pulse_b");
    step(1'b0, 1'b1, 8'd255, "big_step");
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom_range(0, 255)), "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
